// File: rtl/mips_decode_stage.sv
// MIPS decode stage: decodes op/funct into a control bundle held in an ID/EX
// register (1 or 2 entries) with valid/ready handshake, load-use bubble
// insertion and branch flush.
// Optional feature macro: ILLEGAL_OP_TRAP_EN adds the registered illegal_op output.
module mips_decode_stage #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned DEPTH   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic [FUNCT_W-1:0] ALUControl,
  output logic [REG_W-1:0]   dst_reg,
  output logic               stall
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic               reg_write;
    logic               branch;
    logic               branch_ne;
    logic [FUNCT_W-1:0] alu_control;
    logic [REG_W-1:0]   dst;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               illegal;
`endif
  } ctrl_t;

  ctrl_t            dec;
  logic             uses_rt;
  ctrl_t            entry_q [2];
  ctrl_t            entry_n [2];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic             hazard;
  logic             pop;
  logic             push_in;
  logic             push_bub;

  // Opcode/funct decode of the instruction offered by IF/ID
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (op)
      OP_W'(6'b000000): begin
        dec.reg_dst     = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_control = funct;
        uses_rt         = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
        case (funct)
          FUNCT_W'(6'b100000), FUNCT_W'(6'b100001), FUNCT_W'(6'b100010),
          FUNCT_W'(6'b100011), FUNCT_W'(6'b100100), FUNCT_W'(6'b100101),
          FUNCT_W'(6'b100110), FUNCT_W'(6'b100111), FUNCT_W'(6'b101010),
          FUNCT_W'(6'b101011), FUNCT_W'(6'b000000), FUNCT_W'(6'b000010),
          FUNCT_W'(6'b000011): dec.illegal = 1'b0;
          default:             dec.illegal = 1'b1;
        endcase
`endif
      end
      OP_W'(6'b001000): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b100000); end
      OP_W'(6'b001001): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b100001); end
      OP_W'(6'b001100): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b100100); end
      OP_W'(6'b001101): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b100101); end
      OP_W'(6'b001110): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b100110); end
      OP_W'(6'b001010): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b101010); end
      OP_W'(6'b001011): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_control = FUNCT_W'(6'b101011); end
      OP_W'(6'b001111): begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      OP_W'(6'b000100): begin
        dec.branch      = 1'b1;
        dec.alu_control = FUNCT_W'(6'b100010);
        uses_rt         = 1'b1;
      end
      OP_W'(6'b000101): begin
        dec.branch      = 1'b1;
        dec.branch_ne   = 1'b1;
        dec.alu_control = FUNCT_W'(6'b100010);
        uses_rt         = 1'b1;
      end
      OP_W'(6'b100000), OP_W'(6'b100001), OP_W'(6'b100011),
      OP_W'(6'b100100), OP_W'(6'b100101), OP_W'(6'b100111): begin
        dec.mem_to_reg  = 1'b1;
        dec.alu_src     = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_control = FUNCT_W'(6'b100001);
      end
      OP_W'(6'b101000), OP_W'(6'b101001), OP_W'(6'b101011): begin
        dec.mem_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = FUNCT_W'(6'b100001);
        uses_rt         = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
    dec.dst = dec.reg_dst ? rd : rt;
  end

  // Load-use detection against the output entry and handshake derivation
  always_comb begin
    hazard   = in_valid && out_valid && entry_q[0].mem_to_reg &&
               (entry_q[0].dst != '0) &&
               ((entry_q[0].dst == rs) || (uses_rt && (entry_q[0].dst == rt)));
    stall    = hazard && !flush;
    in_ready = !stall && ((count_q < CNT_W'(DEPTH)) || out_ready);
    pop      = out_valid && out_ready;
    push_in  = in_valid && in_ready && !flush;
    push_bub = stall && out_ready;
  end

  // Skid entry update: pop head, then append the decoded instruction or a bubble
  always_comb begin
    entry_n = entry_q;
    count_n = count_q;
    if (flush) begin
      entry_n[0] = '0;
      entry_n[1] = '0;
      count_n    = '0;
    end else begin
      if (pop) begin
        entry_n[0] = entry_q[1];
        entry_n[1] = '0;
        count_n    = count_q - CNT_W'(1);
      end
      if (push_in || push_bub) begin
        entry_n[count_n[0]] = push_bub ? ctrl_t'('0) : dec;
        count_n             = count_n + CNT_W'(1);
      end
    end
  end

  // ID/EX register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      count_q    <= '0;
      out_valid  <= 1'b0;
    end else begin
      entry_q[0] <= entry_n[0];
      entry_q[1] <= entry_n[1];
      count_q    <= count_n;
      out_valid  <= (count_n != '0);
    end
  end

  assign MemtoReg   = entry_q[0].mem_to_reg;
  assign MemWrite   = entry_q[0].mem_write;
  assign ALUSrc     = entry_q[0].alu_src;
  assign RegDst     = entry_q[0].reg_dst;
  assign RegWrite   = entry_q[0].reg_write;
  assign Branch     = entry_q[0].branch;
  assign BranchNe   = entry_q[0].branch_ne;
  assign ALUControl = entry_q[0].alu_control;
  assign dst_reg    = entry_q[0].dst;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = entry_q[0].illegal;
`endif

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage (DEPTH=2): reference model with an
// expected-output queue plus per-scenario directed checks.
module tb_mips_decode_stage;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DEPTH   = 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, flush, out_valid, out_ready, stall;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic MemtoReg, MemWrite, ALUSrc, RegDst, RegWrite, Branch, BranchNe;
  logic [5:0] ALUControl;
  logic [4:0] dst_reg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic mtr, mw, asrc, rdst, rw, br, bne;
    logic [5:0] aluc;
    logic [4:0] dst;
    logic ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mips_decode_stage #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .RegWrite(RegWrite), .Branch(Branch), .BranchNe(BranchNe),
    .ALUControl(ALUControl), .dst_reg(dst_reg), .stall(stall)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  function automatic exp_t model_decode(input logic [5:0] o, input logic [5:0] f,
                                        input logic [4:0] t, input logic [4:0] d);
    exp_t e;
    e = '0;
    case (o)
      6'b000000: begin
        e.rdst = 1'b1; e.rw = 1'b1; e.aluc = f;
        e.ill = !(f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                            6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                            6'b000000, 6'b000010, 6'b000011});
      end
      6'b001000: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100000; end
      6'b001001: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100001; end
      6'b001100: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100100; end
      6'b001101: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100101; end
      6'b001110: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100110; end
      6'b001010: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b101010; end
      6'b001011: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b101011; end
      6'b001111: begin e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b000000; end
      6'b000100: begin e.br = 1'b1; e.aluc = 6'b100010; end
      6'b000101: begin e.br = 1'b1; e.bne = 1'b1; e.aluc = 6'b100010; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        e.mtr = 1'b1; e.asrc = 1'b1; e.rw = 1'b1; e.aluc = 6'b100001;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        e.mw = 1'b1; e.asrc = 1'b1; e.aluc = 6'b100001;
      end
      default: e.ill = 1'b1;
    endcase
    e.dst = e.rdst ? d : t;
`ifndef ILLEGAL_OP_TRAP_EN
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic uses_rt_m(input logic [5:0] o);
    return o inside {6'b000000, 6'b000100, 6'b000101, 6'b101000, 6'b101001, 6'b101011};
  endfunction

  // Scoreboard: compare the head of the expected queue, then advance the model
  exp_t act, hd, bub;
  logic exp_v, hz, ir_e;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      exp_v = (q.size() != 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_v, $time);
      end
      act = '0;
      act.mtr = MemtoReg; act.mw = MemWrite; act.asrc = ALUSrc; act.rdst = RegDst;
      act.rw = RegWrite; act.br = Branch; act.bne = BranchNe;
      act.aluc = ALUControl; act.dst = dst_reg;
`ifdef ILLEGAL_OP_TRAP_EN
      act.ill = illegal_op;
`endif
      if (exp_v) begin
        hd = q[0];
        checks++;
        if (act !== hd) begin
          errors++;
          $display("FAIL bundle: got %h want %h at %0t", act, hd, $time);
        end
      end
      hz   = in_valid && exp_v && hd.mtr && (hd.dst != 5'd0) &&
             ((hd.dst == rs) || (uses_rt_m(op) && (hd.dst == rt)));
      ir_e = !hz && ((q.size() < int'(DEPTH)) || out_ready);
      if (!flush) begin
        checks++;
        if (stall !== hz) begin
          errors++;
          $display("FAIL stall: got %b want %b at %0t", stall, hz, $time);
        end
        checks++;
        if (in_ready !== ir_e) begin
          errors++;
          $display("FAIL in_ready: got %b want %b at %0t", in_ready, ir_e, $time);
        end
      end
      if (exp_v && out_ready) void'(q.pop_front());
      bub = '0;
      if (flush) q.delete();
      else if (hz && out_ready) q.push_back(bub);
      else if (in_valid && ir_e) q.push_back(model_decode(op, funct, rt, rd));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one instruction until accepted; returns at posedge+1 after capture
  task automatic send(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, output int stalls);
    int n;
    bit acc;
    op = o; funct = f; rs = s; rt = t; rd = d; in_valid = 1'b1;
    stalls = 0; acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: op %b not accepted, want accept within 50 cycles", o);
    end
  endtask

  task automatic test_reset();
    int st;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got valid %b stall %b want 0 0", out_valid, stall);
    end
    checks++;
    if ({MemtoReg, MemWrite, ALUSrc, RegDst, RegWrite, Branch, BranchNe, ALUControl, dst_reg} !== 18'd0) begin
      errors++; $display("FAIL reset_ctrl: got nonzero controls, want 0");
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(6'b100011, 6'd0, 5'd1, 5'd3, 5'd0, st);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    op = 6'b000000; funct = 6'b100000; rs = 5'd3; rt = 5'd4; rd = 5'd6; in_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL pre_reset_stall: got %b want 1", stall);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid %b stall %b want 0 0", out_valid, stall);
    end
    checks++;
    if ({MemtoReg, MemWrite, ALUSrc, RegDst, RegWrite, Branch, BranchNe, ALUControl, dst_reg} !== 18'd0) begin
      errors++; $display("FAIL async_reset_ctrl: got nonzero controls, want 0");
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL no_bubble_after_reset: got %b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    int st;
    out_ready = 1'b1;
    send(6'b001000, 6'b111111, 5'd1, 5'd5, 5'd9, st);
    checks++;
    if (out_valid !== 1'b1 || ALUSrc !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0 ||
        ALUControl !== 6'b100000 || dst_reg !== 5'd5) begin
      errors++;
      $display("FAIL addi: got v%b src%b rw%b rdst%b alu%b dst%0d want v1 src1 rw1 rdst0 alu100000 dst5",
               out_valid, ALUSrc, RegWrite, RegDst, ALUControl, dst_reg);
    end
    idle(1);
  endtask

  task automatic test_load_use();
    int st;
    out_ready = 1'b1;
    send(6'b100011, 6'd0, 5'd2, 5'd8, 5'd0, st);
    op = 6'b000000; funct = 6'b100000; rs = 5'd8; rt = 5'd9; rd = 5'd10; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL lu_stall: got stall %b ready %b want 1 0", stall, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || out_valid !== 1'b1 || RegWrite !== 1'b0 || MemtoReg !== 1'b0 ||
        ALUControl !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_bubble: got stall %b v %b rw %b mtr %b alu %b ready %b want 0 1 0 0 000000 1",
               stall, out_valid, RegWrite, MemtoReg, ALUControl, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (RegDst !== 1'b1 || RegWrite !== 1'b1 || ALUControl !== 6'b100000 || dst_reg !== 5'd10) begin
      errors++;
      $display("FAIL lu_add: got rdst %b rw %b alu %b dst %0d want 1 1 100000 10",
               RegDst, RegWrite, ALUControl, dst_reg);
    end
    send(6'b100011, 6'd0, 5'd2, 5'd8, 5'd0, st);
    send(6'b101011, 6'd0, 5'd1, 5'd8, 5'd0, st);
    checks++;
    if (st != 1) begin
      errors++; $display("FAIL lu_store_rt: got %0d stall cycles want 1", st);
    end
    send(6'b100011, 6'd0, 5'd2, 5'd8, 5'd0, st);
    send(6'b001000, 6'd0, 5'd1, 5'd8, 5'd0, st);
    checks++;
    if (st != 0) begin
      errors++; $display("FAIL lu_addi_rt_dest: got %0d stall cycles want 0", st);
    end
    idle(2);
  endtask

  task automatic test_reg0();
    int st;
    out_ready = 1'b1;
    send(6'b100011, 6'd0, 5'd2, 5'd0, 5'd0, st);
    send(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd11, st);
    checks++;
    if (st != 0) begin
      errors++; $display("FAIL reg0_no_stall: got %0d stall cycles want 0", st);
    end
    idle(2);
  endtask

  task automatic test_flush();
    int st;
    out_ready = 1'b1;
    op = 6'b000101; funct = 6'd0; rs = 5'd4; rt = 5'd5; rd = 5'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bne: got out_valid %b want 0", out_valid);
    end
    send(6'b100011, 6'd0, 5'd2, 5'd7, 5'd0, st);
    op = 6'b000000; funct = 6'b100000; rs = 5'd7; rt = 5'd1; rd = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_stalled: got out_valid %b want 0", out_valid);
    end
    idle(1);
  endtask

  task automatic test_backpressure();
    logic [5:0] bp_op [4];
    logic [4:0] got [4];
    int idx, ng;
    bit acc;
    bp_op = '{6'b001101, 6'b001100, 6'b001110, 6'b001010};
    idx = 0; ng = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      op = bp_op[idx]; funct = 6'd0; rs = 5'd0; rt = 5'(idx + 1); rd = 5'd0; in_valid = 1'b1;
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != 2) begin
      errors++; $display("FAIL bp_accepted: got %0d want 2", idx);
    end
    checks++;
    if (out_valid !== 1'b1 || ALUControl !== 6'b100101 || dst_reg !== 5'd1) begin
      errors++; $display("FAIL bp_hold: got v %b alu %b dst %0d want 1 100101 1", out_valid, ALUControl, dst_reg);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin op = bp_op[idx]; rt = 5'(idx + 1); end
      @(negedge clk);
      acc = in_valid && (in_ready === 1'b1);
      if (out_valid === 1'b1 && ng < 4) begin got[ng] = dst_reg; ng++; end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (ng != 4) begin
      errors++; $display("FAIL bp_count: got %0d deliveries want 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 5'(i + 1)) begin
          errors++; $display("FAIL bp_order%0d: got dst %0d want %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

`ifdef ILLEGAL_OP_TRAP_EN
  task automatic test_illegal();
    int st;
    out_ready = 1'b1;
    send(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, st);
    checks++;
    if (illegal_op !== 1'b1 || out_valid !== 1'b1 ||
        {MemtoReg, MemWrite, ALUSrc, RegDst, RegWrite, Branch, BranchNe, ALUControl} !== 13'd0) begin
      errors++; $display("FAIL illegal_op: got ill %b v %b alu %b want 1 1 000000", illegal_op, out_valid, ALUControl);
    end
    send(6'b000000, 6'b001000, 5'd1, 5'd2, 5'd3, st);
    checks++;
    if (illegal_op !== 1'b1) begin
      errors++; $display("FAIL illegal_funct: got %b want 1", illegal_op);
    end
    send(6'b001000, 6'd0, 5'd1, 5'd2, 5'd3, st);
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL legal_addi: got %b want 0", illegal_op);
    end
    idle(2);
  endtask
`endif

  task automatic test_back_to_back();
    logic [5:0] ops [16];
    logic [5:0] fns [4];
    ops = '{6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011,
            6'b001111, 6'b000100, 6'b000101, 6'b100011, 6'b100000, 6'b101011, 6'b111111, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b101010, 6'b001000};
    for (int c = 0; c < 120; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op        = ops[$urandom_range(0, 15)];
      funct     = fns[$urandom_range(0, 3)];
      rs        = 5'($urandom_range(0, 3));
      rt        = 5'($urandom_range(0, 3));
      rd        = 5'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_reg0();
    test_flush();
    test_backpressure();
`ifdef ILLEGAL_OP_TRAP_EN
    test_illegal();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
